// File: rtl/gaussian_clt_gen.sv
// CLT Gaussian noise: per channel, sums SUM_TERMS LFSR uniform slices, then centres, shifts and saturates; GAUSS_ANTITHETIC_EN adds a negated MIRROR sample.
// First sample SUM_TERMS+1 cycles after enable; DONE/MIRROR hold random_number until out_ready, and the LFSRs stay frozen meanwhile.
module gaussian_clt_gen #(
  parameter int          WIDTH     = 16,
  parameter int          NUM_CH    = 1,
  parameter int          SUM_TERMS = 4,
  parameter int          OUT_SHIFT = 2,
  parameter logic [31:0] SEED      = 32'hACE12025
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gauss_en,
  input  logic                    seed_load,
  input  logic [31:0]             seed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] random_number
);

  localparam int AW   = 12 + $clog2(SUM_TERMS);
  localparam int CNTW = $clog2(SUM_TERMS);
  localparam int CW   = 34;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic signed [CW-1:0] SAT_MAX = (CW'(1) << (WIDTH-1)) - CW'(1);
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [CW-1:0] OFFSET  = CW'(SUM_TERMS) << 11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef GAUSS_ANTITHETIC_EN
  localparam logic [1:0] S_MIRROR = 2'd3;
`endif

  // Channels are decorrelated by a golden-ratio stride; zero would lock the LFSR.
  function automatic logic [31:0] ch_seed(input logic [31:0] base, input logic [31:0] ch);
    logic [31:0] s;
    s = base ^ (32'h9E3779B9 * ch);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'd0);
  endfunction

  function automatic logic [WIDTH-1:0] scale(input logic [AW-1:0] sum);
    logic signed [CW-1:0] cen;
    logic signed [CW-1:0] shf;
    cen = $signed(CW'(sum)) - OFFSET;
    shf = cen >>> OUT_SHIFT;
    if (shf > SAT_MAX) return WIDTH'(SAT_MAX);
    if (shf < SAT_MIN) return WIDTH'(SAT_MIN);
    return WIDTH'(shf);
  endfunction

`ifdef GAUSS_ANTITHETIC_EN
  function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] x);
    if (x == {1'b1, {(WIDTH-1){1'b0}}}) return {1'b0, {(WIDTH-1){1'b1}}};
    return -x;
  endfunction
`endif

  logic [1:0]              r_state;
  logic [CNTW-1:0]         r_cnt;
  logic [31:0]             r_lfsr [NUM_CH];
  logic [AW-1:0]           r_acc  [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] r_rnd;
  logic [AW-1:0]           w_sum  [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] w_sample;
  logic                    w_last;

  assign w_last = (r_cnt == CNTW'(SUM_TERMS - 1));

  always_comb begin
    w_sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum[c] = r_acc[c] + AW'(r_lfsr[c][11:0]);
      w_sample[c*WIDTH +: WIDTH] = scale(w_sum[c]);
    end
  end

`ifdef GAUSS_ANTITHETIC_EN
  logic [NUM_CH*WIDTH-1:0] w_mirror;
  always_comb begin
    w_mirror = '0;
    for (int c = 0; c < NUM_CH; c++)
      w_mirror[c*WIDTH +: WIDTH] = neg_sat(r_rnd[c*WIDTH +: WIDTH]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rnd   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_lfsr[c] <= ch_seed(SEED, 32'(c));
        r_acc[c]  <= '0;
      end
    end else if (seed_load) begin
      // Reseed wins over everything, including a sample awaiting handshake.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_lfsr[c] <= ch_seed(seed, 32'(c));
        r_acc[c]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (gauss_en) r_state <= S_ACC;
        S_ACC: if (gauss_en) begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_lfsr[c] <= lfsr_step(r_lfsr[c]);
            r_acc[c]  <= w_last ? '0 : w_sum[c];
          end
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_rnd   <= w_sample;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
`ifdef GAUSS_ANTITHETIC_EN
          r_rnd   <= w_mirror;
          r_state <= S_MIRROR;
`else
          r_state <= gauss_en ? S_ACC : S_IDLE;
`endif
        end
`ifdef GAUSS_ANTITHETIC_EN
        S_MIRROR: if (out_ready) r_state <= gauss_en ? S_ACC : S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GAUSS_ANTITHETIC_EN
  assign out_valid = (r_state == S_DONE) || (r_state == S_MIRROR);
`else
  assign out_valid = (r_state == S_DONE);
`endif
  assign random_number = r_rnd;

endmodule

// File: tb/tb_gaussian_clt_gen.sv
// Bench for gaussian_clt_gen (WIDTH=8, NUM_CH=2): directed timing vectors plus a sample-stream model checked on every valid cycle.
module tb_gaussian_clt_gen;
  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int ST  = 4;
  localparam int OS  = 2;
  localparam logic [31:0] SEED_DEF = 32'hACE12025;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gauss_en = 1'b0;
  logic seed_load = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] seed = 32'd0;
  logic out_valid;
  logic [NCH*W-1:0] random_number;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gaussian_clt_gen #(.WIDTH(W), .NUM_CH(NCH), .SUM_TERMS(ST), .OUT_SHIFT(OS), .SEED(SEED_DEF)) dut (
    .clk(clk), .rst(rst), .gauss_en(gauss_en), .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .random_number(random_number)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stream of samples is a pure function of the seed and of how many samples were accepted.
  logic [31:0]      m_lfsr [NCH];
  logic [NCH*W-1:0] m_exp;
  bit               m_have = 1'b0;

  task automatic m_reseed(input logic [31:0] b);
    logic [31:0] s;
    for (int c = 0; c < NCH; c++) begin
      s = b ^ (32'h9E3779B9 * 32'(c));
      m_lfsr[c] = (s == 32'd0) ? 32'd1 : s;
    end
  endtask

  task automatic m_gen(output logic [NCH*W-1:0] v);
    int sum, cen, q, lo, hi;
    lo = -(1 << (W-1));
    hi = (1 << (W-1)) - 1;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      sum = 0;
      for (int t = 0; t < ST; t++) begin
        sum += int'(m_lfsr[c][11:0]);
        m_lfsr[c] = (m_lfsr[c] >> 1) ^ (m_lfsr[c][0] ? 32'h80200003 : 32'h0);
      end
      cen = sum - ST * 2048;
      q = cen / (1 << OS);
      if ((cen % (1 << OS)) != 0 && cen < 0) q = q - 1;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      v[c*W +: W] = q[W-1:0];
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_reseed(SEED_DEF);
      m_have = 1'b0;
    end else begin
      if (out_valid) begin
        if (!m_have) begin
          m_gen(m_exp);
          m_have = 1'b1;
        end
        check("stream_sample", 64'(random_number), 64'(m_exp));
      end
      if (seed_load) begin
        m_reseed(seed);
        m_have = 1'b0;
      end else if (out_valid && out_ready) begin
        m_have = 1'b0;
      end
    end
  end

  // Pulse seed_load, then count cycles (cycle 0 = first IDLE cycle) until out_valid; optional gauss_en pause.
  task automatic run_sample(input logic [31:0] sd, input int p0, input int plen, output int lat);
    @(posedge clk); #1;
    seed_load = 1'b1; seed = sd; gauss_en = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    lat = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      gauss_en = !(cyc >= p0 && cyc < p0 + plen);
      @(negedge clk);
      if (out_valid) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    gauss_en = 1'b1;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nv, nhs;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", 64'(random_number), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_disabled_valid", 64'(out_valid), 64'd0);
    end

    // Seed 0: ch0 terms 1,3,2,1 -> -2047 -> 8'h80; ch1 sum 13370 -> 1294 -> 8'h7F.
    out_ready = 1'b0;
    run_sample(32'd0, 100, 0, lat);
    check("first_latency", 64'(lat), 64'd5);
    check("first_sample", 64'(random_number), 64'h7F80);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid(20, lat);
    check("period_after_stall", 64'(lat), 64'd4);

    run_sample(32'd0, 3, 3, lat);
    check("pause_latency", 64'(lat), 64'd8);
    check("pause_sample", 64'(random_number), 64'h7F80);

    run_sample(32'h12345678, 100, 0, lat);
    check("reseed_in_done_latency", 64'(lat), 64'd5);

    @(posedge clk); #1;
    seed_load = 1'b1; seed = 32'hDEADBEEF; gauss_en = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_sample(32'h0BADF00D, 100, 0, lat);
    check("reseed_mid_acc_latency", 64'(lat), 64'd5);

    out_ready = 1'b1;
    run_sample(32'hCAFEF00D, 100, 0, lat);
    check("sustained_first_latency", 64'(lat), 64'd5);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("sustained_count", 64'(nv), 64'd20);

    nhs = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      out_ready = ((cyc % 7) != 3) && ((cyc % 13) != 0);
      gauss_en  = (cyc % 11) != 5;
      seed_load = (cyc % 600) == 300;
      seed      = 32'(cyc) * 32'h01000193;
      @(negedge clk);
      if (out_valid && out_ready && !seed_load) nhs++;
    end
    @(posedge clk); #1;
    seed_load = 1'b0; gauss_en = 1'b1;
    check("stream_progress", 64'(nhs > 150), 64'd1);

    out_ready = 1'b0;
    run_sample(32'h55AA55AA, 100, 0, lat);
    @(posedge clk); #1;
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("reset_mid_acc_valid", 64'(out_valid), 64'd0);
    check("reset_mid_acc_data", 64'(random_number), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_valid(20, lat);
    check("after_reset_latency", 64'(lat), 64'd5);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("reset_in_done_valid", 64'(out_valid), 64'd0);
    check("reset_in_done_data", 64'(random_number), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    wait_valid(20, lat);
    check("after_reset2_latency", 64'(lat), 64'd5);
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
